// File: rtl/stream_turbo_frame_ctrl_pkg.sv
// Shared types and helpers for the turbo frame controller.
package turbo_ctrl_pkg;

    // Frame sequencing states.
    typedef enum logic [2:0] {
        LOAD  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        EMIT  = 3'd3,
        DRAIN = 3'd4
    } state_e;

    // Width needed to index 0..depth-1, never narrower than one bit.
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // The last half-iteration runs interleaved when the half-iteration count is even.
    function automatic bit final_order_interleaved(input int unsigned half_iter);
        return (half_iter % 2) == 0;
    endfunction

endpackage

// File: rtl/stream_turbo_frame_ctrl_prime_interleave_counter.sv
// Incremental address generator: k (natural) or (k*P) mod N (interleaved), no multiplier.
module prime_interleave_counter
    import turbo_ctrl_pkg::*;
#(
    parameter int unsigned N = 8,
    parameter int unsigned P = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       step,
    input  logic                       natural_mode,
    output logic [addr_width(N)-1:0]   addr
);

    localparam int unsigned IW = addr_width(N);
    localparam int unsigned SW = IW + 1;

    logic [IW-1:0] r_addr;
    logic [SW-1:0] w_inc;
    logic [SW-1:0] w_sum;
    logic [SW-1:0] w_wrapped;

    // Next address: add the step and fold back once into 0..N-1.
    always_comb begin
        w_inc     = natural_mode ? SW'(1) : SW'(P);
        w_sum     = SW'(r_addr) + w_inc;
        w_wrapped = (w_sum >= SW'(N)) ? (w_sum - SW'(N)) : w_sum;
    end

    // Accumulator register; clear has priority over step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr <= '0;
        end else if (clear) begin
            r_addr <= '0;
        end else if (step) begin
            r_addr <= IW'(w_wrapped);
        end
    end

    assign addr = r_addr;

endmodule

// File: rtl/stream_turbo_frame_ctrl.sv
// Frame sequencer: load symbols, run half-iterations on the SISO, stream decisions out.
module stream_turbo_frame_ctrl
    import turbo_ctrl_pkg::*;
#(
    parameter int unsigned N         = 8,
    parameter int unsigned P         = 3,
    parameter int unsigned TAIL_BITS = 2,
    parameter int unsigned HALF_ITER = 3,
    parameter int unsigned AW        = addr_width(N + TAIL_BITS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic          siso_start,
    output logic          siso_interleaved,
    input  logic          siso_done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic          dec_bit,
    output logic          out_valid,
    output logic          x,
    output logic          busy,
    output logic          frame_done
);

    localparam int unsigned HW       = addr_width(HALF_ITER);
    localparam int unsigned IW       = addr_width(N);
    localparam bit          FINAL_IL = final_order_interleaved(HALF_ITER);

    state_e        r_state;
    state_e        w_state_nxt;
    // Shared counter: symbols in LOAD, k in EMIT, drain cycles in DRAIN.
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] w_cnt_nxt;
    logic [HW-1:0] r_hc;
    logic [HW-1:0] w_hc_nxt;
    logic          r_siso_il;
    logic          r_rd_d;
    logic          r_last_d;
    logic          r_out_valid;
    logic          r_frame_done;
    logic          r_x;
    logic          w_last_k;
    logic          w_il_clear;
    logic          w_il_natural;
    logic [IW-1:0] w_il_addr;

    // State, counters and the registered interleave flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= LOAD;
            r_cnt     <= '0;
            r_hc      <= '0;
            r_siso_il <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hc    <= w_hc_nxt;
            if (w_state_nxt == START || w_state_nxt == WAIT) begin
                r_siso_il <= w_hc_nxt[0];
            end
        end
    end

    // Next-state logic and per-state control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hc_nxt    = r_hc;
        in_ready    = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = '0;
        siso_start  = 1'b0;
        rd_en       = 1'b0;
        w_last_k    = 1'b0;
        busy        = 1'b1;
        unique case (r_state)
            LOAD: begin
                busy     = 1'b0;
                in_ready = 1'b1;
                if (in_valid && !reset) begin
                    wr_en   = 1'b1;
                    wr_addr = r_cnt;
                    if (r_cnt == AW'(N + TAIL_BITS - 1)) begin
                        w_cnt_nxt   = '0;
                        w_hc_nxt    = '0;
                        w_state_nxt = START;
                    end else begin
                        w_cnt_nxt = r_cnt + AW'(1);
                    end
                end
            end
            START: begin
                siso_start  = 1'b1;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (siso_done) begin
                    if (r_hc == HW'(HALF_ITER - 1)) begin
                        w_state_nxt = EMIT;
                    end else begin
                        w_hc_nxt    = r_hc + HW'(1);
                        w_state_nxt = START;
                    end
                end
            end
            EMIT: begin
                rd_en = 1'b1;
                if (r_cnt == AW'(N - 1)) begin
                    w_last_k    = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = DRAIN;
                end else begin
                    w_cnt_nxt = r_cnt + AW'(1);
                end
            end
            DRAIN: begin
                if (r_cnt == AW'(1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = LOAD;
                end else begin
                    w_cnt_nxt = r_cnt + AW'(1);
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = LOAD;
            end
        endcase
    end

    assign w_il_clear   = (r_state != EMIT);
    assign w_il_natural = ~FINAL_IL;

    prime_interleave_counter #(
        .N (N),
        .P (P)
    ) u_il_cnt (
        .clk          (clk),
        .reset        (reset),
        .clear        (w_il_clear),
        .step         (rd_en),
        .natural_mode (w_il_natural),
        .addr         (w_il_addr)
    );

    assign rd_addr = AW'(w_il_addr);

    // Output pipeline: decision arrives one cycle after rd_en, registered once more.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_d       <= 1'b0;
            r_last_d     <= 1'b0;
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_x          <= 1'b0;
        end else begin
            r_rd_d       <= rd_en;
            r_last_d     <= w_last_k;
            r_out_valid  <= r_rd_d;
            r_frame_done <= r_last_d;
            r_x          <= dec_bit;
        end
    end

    assign siso_interleaved = r_siso_il;
    assign out_valid        = r_out_valid;
    assign frame_done       = r_frame_done;
    assign x                = r_x;

endmodule

// File: tb/tb_stream_turbo_frame_ctrl.sv
// Directed bench: DUT A (HALF_ITER=3) and DUT B (HALF_ITER=2) with SISO and decision-memory models.
module tb_stream_turbo_frame_ctrl;

    localparam int unsigned AW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bit pat [0:7] = '{1, 0, 1, 1, 0, 0, 1, 0};

    // DUT A signals
    logic          a_in_valid, a_in_ready, a_wr_en, a_siso_start, a_siso_il;
    logic          a_pulse, a_tie, a_siso_done, a_rd_en, a_dec, a_out_valid, a_x, a_busy, a_fd;
    logic [AW-1:0] a_wr_addr, a_rd_addr;
    // DUT B signals
    logic          b_in_valid, b_in_ready, b_wr_en, b_siso_start, b_siso_il;
    logic          b_pulse, b_siso_done, b_rd_en, b_dec, b_out_valid, b_x, b_busy, b_fd;
    logic [AW-1:0] b_wr_addr, b_rd_addr;

    assign a_siso_done = a_pulse | a_tie;
    assign b_siso_done = b_pulse;

    stream_turbo_frame_ctrl #(.N(8), .P(3), .TAIL_BITS(2), .HALF_ITER(3)) u_dut_a (
        .clk(clk), .reset(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .siso_start(a_siso_start),
        .siso_interleaved(a_siso_il), .siso_done(a_siso_done), .rd_en(a_rd_en),
        .rd_addr(a_rd_addr), .dec_bit(a_dec), .out_valid(a_out_valid), .x(a_x),
        .busy(a_busy), .frame_done(a_fd)
    );

    stream_turbo_frame_ctrl #(.N(8), .P(3), .TAIL_BITS(2), .HALF_ITER(2)) u_dut_b (
        .clk(clk), .reset(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .siso_start(b_siso_start),
        .siso_interleaved(b_siso_il), .siso_done(b_siso_done), .rd_en(b_rd_en),
        .rd_addr(b_rd_addr), .dec_bit(b_dec), .out_valid(b_out_valid), .x(b_x),
        .busy(b_busy), .frame_done(b_fd)
    );

    // Logs of observed activity
    int qa_wr[$], qa_wr_cyc[$], qa_st_cyc[$], qa_st_il[$], qa_rd[$], qa_rd_cyc[$];
    int qa_x[$], qa_ov_cyc[$], qa_fd_cyc[$], qa_ir_rise[$];
    bit a_ir_prev = 1'b0;
    int qb_st_il[$], qb_rd[$], qb_rd_il[$], qb_x[$];
    int qb_fd_n = 0;

    // SISO model A: done pulse 5 cycles after each start unless tied high.
    initial begin
        a_pulse = 1'b0;
        forever begin
            @(negedge clk);
            if (a_siso_start && !a_tie) begin
                repeat (5) @(posedge clk);
                #1 a_pulse = 1'b1;
                @(posedge clk);
                #1 a_pulse = 1'b0;
            end
        end
    end

    // SISO model B
    initial begin
        b_pulse = 1'b0;
        forever begin
            @(negedge clk);
            if (b_siso_start) begin
                repeat (5) @(posedge clk);
                #1 b_pulse = 1'b1;
                @(posedge clk);
                #1 b_pulse = 1'b0;
            end
        end
    end

    // Decision memory A: one-cycle read latency
    initial begin : dec_mem_a
        bit v;
        a_dec = 1'b0;
        forever begin
            @(negedge clk);
            if (a_rd_en) begin
                v = pat[a_rd_addr[2:0]];
                @(posedge clk);
                #1 a_dec = v;
            end
        end
    end

    // Decision memory B
    initial begin : dec_mem_b
        bit v;
        b_dec = 1'b0;
        forever begin
            @(negedge clk);
            if (b_rd_en) begin
                v = pat[b_rd_addr[2:0]];
                @(posedge clk);
                #1 b_dec = v;
            end
        end
    end

    // Monitor A
    initial forever begin
        @(negedge clk);
        if (a_wr_en) begin qa_wr.push_back(int'(a_wr_addr)); qa_wr_cyc.push_back(cyc); end
        if (a_siso_start) begin qa_st_cyc.push_back(cyc); qa_st_il.push_back(int'(a_siso_il)); end
        if (a_rd_en) begin qa_rd.push_back(int'(a_rd_addr)); qa_rd_cyc.push_back(cyc); end
        if (a_out_valid) begin qa_x.push_back(int'(a_x)); qa_ov_cyc.push_back(cyc); end
        if (a_fd) qa_fd_cyc.push_back(cyc);
        if (a_in_ready && !a_ir_prev) qa_ir_rise.push_back(cyc);
        a_ir_prev = a_in_ready;
    end

    // Monitor B
    initial forever begin
        @(negedge clk);
        if (b_siso_start) qb_st_il.push_back(int'(b_siso_il));
        if (b_rd_en) begin qb_rd.push_back(int'(b_rd_addr)); qb_rd_il.push_back(int'(b_siso_il)); end
        if (b_out_valid) qb_x.push_back(int'(b_x));
        if (b_fd) qb_fd_n++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_a();
        qa_wr.delete(); qa_wr_cyc.delete(); qa_st_cyc.delete(); qa_st_il.delete();
        qa_rd.delete(); qa_rd_cyc.delete(); qa_x.delete(); qa_ov_cyc.delete();
        qa_fd_cyc.delete(); qa_ir_rise.delete();
    endtask

    task automatic check_reset_a(input string tag);
        chk({tag, "_in_ready"}, 32'(a_in_ready), 1);
        chk({tag, "_busy"}, 32'(a_busy), 0);
        chk({tag, "_others"}, 32'({a_wr_en, a_siso_start, a_siso_il, a_rd_en, a_out_valid,
                                   a_x, a_fd, a_wr_addr, a_rd_addr}), 0);
    endtask

    task automatic check_reset_b(input string tag);
        chk({tag, "_in_ready"}, 32'(b_in_ready), 1);
        chk({tag, "_others"}, 32'({b_wr_en, b_siso_start, b_siso_il, b_rd_en, b_out_valid,
                                   b_x, b_busy, b_fd, b_wr_addr, b_rd_addr}), 0);
    endtask

    // Stream 10 symbols into A with 'gap' idle cycles after each.
    task automatic stream_a(input int gap);
        for (int i = 0; i < 10; i++) begin
            a_in_valid = 1'b1;
            tick(1);
            a_in_valid = 1'b0;
            if (gap > 0) tick(gap);
        end
    endtask

    task automatic wait_fd_a(input string tag, input int target, input int bound);
        int t = 0;
        while (qa_fd_cyc.size() < target && t < bound) begin
            tick(1);
            t++;
        end
        chk({tag, "_fd_timeout"}, 32'(qa_fd_cyc.size() >= target), 1);
    endtask

    // Full-frame check for A; sp = cycles between successive starts.
    task automatic check_frame_a(input string tag, input int sp);
        int il_exp [0:2] = '{0, 1, 0};
        chk({tag, "_nwr"}, qa_wr.size(), 10);
        for (int i = 0; i < 10; i++) chk({tag, "_wr_addr"}, qget(qa_wr, i), i);
        chk({tag, "_nstart"}, qa_st_cyc.size(), 3);
        for (int i = 0; i < 3; i++) chk({tag, "_start_il"}, qget(qa_st_il, i), il_exp[i]);
        chk({tag, "_start0_cyc"}, qget(qa_st_cyc, 0), qget(qa_wr_cyc, 9) + 1);
        chk({tag, "_start_sp1"}, qget(qa_st_cyc, 1) - qget(qa_st_cyc, 0), sp);
        chk({tag, "_start_sp2"}, qget(qa_st_cyc, 2) - qget(qa_st_cyc, 1), sp);
        chk({tag, "_nrd"}, qa_rd.size(), 8);
        for (int i = 0; i < 8; i++) chk({tag, "_rd_addr"}, qget(qa_rd, i), i);
        for (int i = 0; i < 8; i++) chk({tag, "_x"}, qget(qa_x, i), int'(pat[i]));
        chk({tag, "_rd0_cyc"}, qget(qa_rd_cyc, 0), qget(qa_st_cyc, 2) + sp);
        chk({tag, "_ov0_cyc"}, qget(qa_ov_cyc, 0), qget(qa_rd_cyc, 0) + 2);
        chk({tag, "_nov"}, qa_ov_cyc.size(), 8);
        chk({tag, "_ov_span"}, qget(qa_ov_cyc, 7) - qget(qa_ov_cyc, 0), 7);
        chk({tag, "_nfd"}, qa_fd_cyc.size(), 1);
        chk({tag, "_fd_cyc"}, qget(qa_fd_cyc, 0), qget(qa_ov_cyc, 7));
    endtask

    initial begin
        int t;
        int exp_b_rd [0:7] = '{0, 3, 6, 1, 4, 7, 2, 5};
        int exp_b_x  [0:7] = '{1, 1, 1, 0, 0, 0, 1, 0};
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        a_tie      = 1'b0;

        // Reset values
        #2 rst = 1'b1;
        tick(3);
        check_reset_a("rst_a");
        check_reset_b("rst_b");
        rst = 1'b0;
        tick(2);

        // Contiguous frame, default parameters
        clear_a();
        stream_a(0);
        chk("t1_in_ready_after_last", 32'(a_in_ready), 0);
        chk("t1_start_after_last", 32'(a_siso_start), 1);
        wait_fd_a("t1", 1, 300);
        chk("t1_in_ready_after_drain", 32'(a_in_ready), 1);
        chk("t1_busy_after_drain", 32'(a_busy), 0);
        check_frame_a("t1", 6);

        // HALF_ITER=2: interleaved final order
        b_in_valid = 1'b1;
        tick(10);
        b_in_valid = 1'b0;
        t = 0;
        while (qb_fd_n < 1 && t < 300) begin tick(1); t++; end
        chk("t2_fd_timeout", 32'(qb_fd_n), 1);
        chk("t2_nstart", qb_st_il.size(), 2);
        chk("t2_start0_il", qget(qb_st_il, 0), 0);
        chk("t2_start1_il", qget(qb_st_il, 1), 1);
        chk("t2_nrd", qb_rd.size(), 8);
        for (int i = 0; i < 8; i++) chk("t2_rd_addr", qget(qb_rd, i), exp_b_rd[i]);
        for (int i = 0; i < 8; i++) chk("t2_emit_il", qget(qb_rd_il, i), 1);
        for (int i = 0; i < 8; i++) chk("t2_x", qget(qb_x, i), exp_b_x[i]);
        tick(2);

        // Gapped input 1,0,0,1,...
        clear_a();
        stream_a(2);
        wait_fd_a("t3", 1, 300);
        check_frame_a("t3", 6);
        chk("t3_wr_span", qget(qa_wr_cyc, 9) - qget(qa_wr_cyc, 0), 27);
        tick(2);

        // siso_done tied high
        clear_a();
        a_tie = 1'b1;
        stream_a(0);
        wait_fd_a("t4", 1, 300);
        check_frame_a("t4", 2);
        a_tie = 1'b0;
        tick(2);

        // Reset asserted during the second WAIT
        clear_a();
        stream_a(0);
        t = 0;
        while (qa_st_cyc.size() < 2 && t < 100) begin tick(1); t++; end
        chk("t5_second_start_seen", qa_st_cyc.size(), 2);
        chk("t5_il_before_rst", 32'(a_siso_il), 1);
        chk("t5_busy_before_rst", 32'(a_busy), 1);
        #2 rst = 1'b1;
        #1;
        check_reset_a("t5_async");
        tick(2);
        rst = 1'b0;
        tick(6);
        clear_a();
        stream_a(0);
        wait_fd_a("t5", 1, 300);
        check_frame_a("t5", 6);
        tick(2);

        // Back-to-back frames with in_valid held high
        clear_a();
        a_in_valid = 1'b1;
        t = 0;
        while (qa_wr.size() < 20 && t < 400) begin tick(1); t++; end
        a_in_valid = 1'b0;
        wait_fd_a("t6", 2, 400);
        chk("t6_nwr", qa_wr.size(), 20);
        chk("t6_wr10_addr", qget(qa_wr, 10), 0);
        chk("t6_wr19_addr", qget(qa_wr, 19), 9);
        chk("t6_nov", qa_ov_cyc.size(), 16);
        chk("t6_nfd", qa_fd_cyc.size(), 2);
        chk("t6_fd0_cyc", qget(qa_fd_cyc, 0), qget(qa_ov_cyc, 7));
        chk("t6_fd1_cyc", qget(qa_fd_cyc, 1), qget(qa_ov_cyc, 15));
        chk("t6_ready_rise", qget(qa_ir_rise, 0), qget(qa_fd_cyc, 0) + 1);
        chk("t6_second_wr_cyc", qget(qa_wr_cyc, 10), qget(qa_ir_rise, 0));
        for (int i = 0; i < 8; i++) chk("t6_x2", qget(qa_x, 8 + i), int'(pat[i]));
        tick(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
